// File: rtl/param_counter.sv
// param_counter: parametrised up/down counter with programmable modulo limit,
// wrap or saturate boundary handling, prescaled count enable, a one-cycle
// terminal-count pulse and a sticky overflow flag.
//
// Parameters:
//   WIDTH    counter/load/limit width (>=2)
//   PRESCALE enabled cycles per count step (>=1)
//   SATURATE 0 = wrap at the boundary, 1 = hold at the boundary
//
// Ports:
//   clk      rising-edge clock
//   clear    synchronous active-high reset (highest priority)
//   en       count enable, feeds the prescaler
//   load     synchronous load of min(d, limit)
//   d        load value
//   up_down  1 = up, 0 = down; sampled on the step cycle
//   limit    top of the count range 0..limit
//   qd       current count (registered)
//   tc       terminal-count pulse, one cycle after a boundary step
//   ovf      sticky boundary flag, cleared by clear or load
module param_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up_down,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] qd,
  output logic             tc,
  output logic             ovf
);

  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PCW-1:0]   pc_q,  pc_d;
  logic             tc_q,  tc_d;
  logic             ovf_q, ovf_d;
  logic             step;

  // A step fires on the last enabled cycle of each prescale period.
  assign step = !load && en && (pc_q == PC_LAST);

  always_comb begin
    cnt_d = cnt_q;
    pc_d  = pc_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (load) begin
      cnt_d = (d > limit) ? limit : d;
      pc_d  = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      pc_d = step ? '0 : pc_q + PCW'(1);
    end

    if (step) begin
      if (up_down) begin
        if (cnt_q < limit) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          // At or above limit counts as hitting the boundary.
          cnt_d = (SATURATE != 0) ? limit : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end else begin
        if (cnt_q > limit) begin
          // Limit was lowered under the count: snap down, not a boundary.
          cnt_d = limit;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          cnt_d = (SATURATE != 0) ? '0 : limit;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
      pc_q  <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign qd  = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: four instances with different parameter sets share
// one stimulus stream; each is compared every cycle against an integer model
// of the counting rules.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       clear, en, load, up_down;
  logic [7:0] d, limit;

  logic [7:0] q0, q1, q2;
  logic [3:0] q3;
  logic [3:0] tcv, ovfv;

  int errs   = 0;
  int checks = 0;

  // per-instance parameters: wrap, saturate, prescale-3 saturate, 4-bit wrap
  int pw[4] = '{8, 8, 8, 4};
  int pp[4] = '{1, 1, 3, 1};
  int ps[4] = '{0, 1, 1, 0};

  int m_q[4], m_pc[4], m_tc[4], m_ovf[4];

  always #5 clk = ~clk;

  param_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(0)) u0 (
    .clk(clk), .clear(clear), .en(en), .load(load), .d(d), .up_down(up_down),
    .limit(limit), .qd(q0), .tc(tcv[0]), .ovf(ovfv[0]));
  param_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(1)) u1 (
    .clk(clk), .clear(clear), .en(en), .load(load), .d(d), .up_down(up_down),
    .limit(limit), .qd(q1), .tc(tcv[1]), .ovf(ovfv[1]));
  param_counter #(.WIDTH(8), .PRESCALE(3), .SATURATE(1)) u2 (
    .clk(clk), .clear(clear), .en(en), .load(load), .d(d), .up_down(up_down),
    .limit(limit), .qd(q2), .tc(tcv[2]), .ovf(ovfv[2]));
  param_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(0)) u3 (
    .clk(clk), .clear(clear), .en(en), .load(load), .d(d[3:0]), .up_down(up_down),
    .limit(limit[3:0]), .qd(q3), .tc(tcv[3]), .ovf(ovfv[3]));

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: one edge of the counting rules, in plain integers.
  task automatic model_edge(input int i);
    int mask, dd, ll;
    mask = (1 << pw[i]) - 1;
    dd   = int'(d) & mask;
    ll   = int'(limit) & mask;
    if (clear) begin
      m_q[i] = 0; m_pc[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end else if (load) begin
      m_q[i] = (dd < ll) ? dd : ll; m_pc[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end else begin
      m_tc[i] = 0;
      if (en) begin
        if (m_pc[i] == pp[i] - 1) begin
          m_pc[i] = 0;
          if (up_down) begin
            if (m_q[i] < ll) m_q[i] = m_q[i] + 1;
            else begin
              m_q[i] = ps[i] ? ll : 0; m_tc[i] = 1; m_ovf[i] = 1;
            end
          end else begin
            if (m_q[i] > ll) m_q[i] = ll;
            else if (m_q[i] > 0) m_q[i] = m_q[i] - 1;
            else begin
              m_q[i] = ps[i] ? 0 : ll; m_tc[i] = 1; m_ovf[i] = 1;
            end
          end
        end else begin
          m_pc[i] = m_pc[i] + 1;
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    int aq[4];
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_edge(i);
    #1;
    aq[0] = int'(q0); aq[1] = int'(q1); aq[2] = int'(q2); aq[3] = int'(q3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("qd[%0d]", i), aq[i], m_q[i]);
      chk($sformatf("tc[%0d]", i), int'(tcv[i]), m_tc[i]);
      chk($sformatf("ovf[%0d]", i), int'(ovfv[i]), m_ovf[i]);
    end
  endtask

  task automatic drive(input logic c, input logic e, input logic l,
                       input logic u, input int dv, input int lv);
    clear = c; en = e; load = l; up_down = u; d = 8'(dv); limit = 8'(lv);
  endtask

  int exp1[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
  int exp2w[5] = '{2, 1, 0, 9, 8};
  int exp2s[5] = '{2, 1, 0, 0, 0};

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_q[i] = 0; m_pc[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
    drive(1, 1, 0, 1, 0, 5);
    #2;

    // 1: reset then count up to limit 5 and wrap
    cycle();
    chk("t1 reset qd", int'(q0), 0);
    chk("t1 reset ovf", int'(ovfv[0]), 0);
    drive(0, 1, 0, 1, 0, 5);
    for (int k = 1; k < 8; k++) begin
      cycle();
      chk($sformatf("t1 qd step%0d", k), int'(q0), exp1[k]);
      chk($sformatf("t1 tc step%0d", k), int'(tcv[0]), (k == 6) ? 1 : 0);
      chk($sformatf("t1 ovf step%0d", k), int'(ovfv[0]), (k >= 6) ? 1 : 0);
    end

    // 2: down from 2 with limit 9, wrap vs saturate
    drive(0, 0, 1, 0, 2, 9);
    cycle();
    chk("t2 load wrap", int'(q0), exp2w[0]);
    chk("t2 load sat", int'(q1), exp2s[0]);
    drive(0, 1, 0, 0, 0, 9);
    for (int k = 1; k < 5; k++) begin
      cycle();
      chk($sformatf("t2 wrap qd%0d", k), int'(q0), exp2w[k]);
      chk($sformatf("t2 sat qd%0d", k), int'(q1), exp2s[k]);
      chk($sformatf("t2 wrap tc%0d", k), int'(tcv[0]), (k == 3) ? 1 : 0);
      chk($sformatf("t2 sat tc%0d", k), int'(tcv[1]), (k >= 3) ? 1 : 0);
    end

    // 3: prescaler, with a 2-cycle enable gap mid-period
    drive(1, 0, 0, 1, 0, 255);
    cycle();
    drive(0, 1, 0, 1, 0, 255);
    for (int k = 0; k < 7; k++) cycle();
    chk("t3 qd after 7", int'(q2), 2);
    drive(0, 0, 0, 1, 0, 255);
    cycle(); cycle();
    drive(0, 1, 0, 1, 0, 255);
    cycle();
    chk("t3 gap held", int'(q2), 2);
    cycle();
    chk("t3 delayed step", int'(q2), 3);
    for (int k = 0; k < 4; k++) cycle();

    // 4: load clamps to limit and clears ovf; clear beats load
    drive(0, 1, 0, 1, 0, 0);
    cycle();
    chk("t4 lim0 ovf", int'(ovfv[0]), 1);
    drive(0, 1, 1, 1, 200, 100);
    cycle();
    chk("t4 clamp", int'(q0), 100);
    chk("t4 ovf clr", int'(ovfv[0]), 0);
    drive(1, 1, 1, 1, 200, 100);
    cycle();
    chk("t4 clear wins", int'(q0), 0);

    // 5: limit lowered under the count
    drive(0, 0, 1, 0, 50, 255);
    cycle();
    drive(0, 1, 0, 0, 0, 20);
    cycle();
    chk("t5 down snap", int'(q0), 20);
    chk("t5 down tc", int'(tcv[0]), 0);
    drive(0, 0, 1, 1, 50, 255);
    cycle();
    drive(0, 1, 0, 1, 0, 20);
    cycle();
    chk("t5 up wrap", int'(q0), 0);
    chk("t5 up sat", int'(q1), 20);
    chk("t5 up tc", int'(tcv[1]), 1);

    // 6: 4-bit full range roll-over, then clear on a boundary edge
    drive(0, 0, 1, 1, 14, 15);
    cycle();
    drive(0, 1, 0, 1, 0, 15);
    cycle();
    chk("t6 at 15", int'(q3), 15);
    cycle();
    chk("t6 roll", int'(q3), 0);
    chk("t6 roll tc", int'(tcv[3]), 1);
    drive(0, 0, 1, 1, 15, 15);
    cycle();
    drive(1, 1, 0, 1, 0, 15);
    cycle();
    chk("t6 clr qd", int'(q3), 0);
    chk("t6 clr tc", int'(tcv[3]), 0);
    chk("t6 clr ovf", int'(ovfv[3]), 0);

    // random soak against the model
    for (int k = 0; k < 3000; k++) begin
      clear   = ($urandom_range(0, 99) < 2);
      load    = ($urandom_range(0, 99) < 5);
      en      = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 15) == 0) up_down = ~up_down;
      d       = 8'($urandom);
      if ($urandom_range(0, 31) == 0)
        limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
